// File: rtl/control_unit.sv
// control_unit: multi-cycle T-state sequencer driving datapath strobes.
// Ports: clk/clr, IR/CON/mem_ready/stop in; r_in/r_out, strobes, ALU_select, run out.
module control_unit #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_INC = 5'b11111
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        mem_ready,
  input  logic        stop,
  output logic [15:0] r_in,
  output logic [15:0] r_out,
  output logic        PC_in,
  output logic        PC_out,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        ZHI_out,
  output logic        ZLOW_out,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        MDR_out,
  output logic        HI_in,
  output logic        HI_out,
  output logic        LO_in,
  output logic        LO_out,
  output logic        inPort_out,
  output logic        outPort_in,
  output logic        C_out,
  output logic        CON_in,
  output logic        IncPC,
  output logic        read,
  output logic        write,
  output logic [4:0]  ALU_select,
  output logic        run
);

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  state_t state;
  state_t last_st;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic unused_ir;

  assign op = IR[31:27];
  assign ra = IR[26:23];
  assign rb = IR[22:19];
  assign rc = IR[18:15];
  assign unused_ir = ^IR[14:0];

  logic c_alu, c_imm, c_md, c_neg, c_ldi, c_ld, c_st;
  logic c_br, c_jr, c_jal, c_in, c_out, c_mfhi, c_mflo, c_halt;
  logic hold;

  assign c_alu  = (op >= 5'd3) && (op <= 5'd8);
  assign c_imm  = (op >= 5'd9) && (op <= 5'd11);
  assign c_md   = (op == 5'd12) || (op == 5'd13);
  assign c_neg  = (op == 5'd14) || (op == 5'd15);
  assign c_ldi  = (op == 5'd1);
  assign c_ld   = (op == 5'd0);
  assign c_st   = (op == 5'd2);
  assign c_br   = (op == 5'd16);
  assign c_jr   = (op == 5'd17);
  assign c_jal  = (op == 5'd18);
  assign c_in   = (op == 5'd19);
  assign c_out  = (op == 5'd20);
  assign c_mfhi = (op == 5'd21);
  assign c_mflo = (op == 5'd22);
  assign c_halt = (op == 5'd25);

  // Final T-state of each instruction class; nop/halt/undefined end at T3.
  always_comb begin
    last_st = T3;
    unique case (1'b1)
      c_alu, c_imm, c_ldi: last_st = T5;
      c_md, c_br:          last_st = T6;
      c_neg, c_jal:        last_st = T4;
      c_ld, c_st:          last_st = T7;
      default:             last_st = T3;
    endcase
  end

  // Memory wait states stall until the pending access completes.
  assign hold = !mem_ready &&
                ((state == T1) ||
                 (state == T6 && c_ld) ||
                 (state == T7 && c_st));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= RESET;
    end else begin
      unique case (state)
        RESET: state <= T0;
        HALT:  state <= HALT;
        default: begin
          if (!hold) begin
            if (state >= T3 && state == last_st)
              state <= (c_halt || stop) ? HALT : T0;
            else
              state <= state_t'(state + 4'd1);
          end
        end
      endcase
    end
  end

  always_comb begin
    r_in       = '0;
    r_out      = '0;
    PC_in      = 1'b0;
    PC_out     = 1'b0;
    IR_in      = 1'b0;
    Y_in       = 1'b0;
    Z_in       = 1'b0;
    ZHI_out    = 1'b0;
    ZLOW_out   = 1'b0;
    MAR_in     = 1'b0;
    MDR_in     = 1'b0;
    MDR_out    = 1'b0;
    HI_in      = 1'b0;
    HI_out     = 1'b0;
    LO_in      = 1'b0;
    LO_out     = 1'b0;
    inPort_out = 1'b0;
    outPort_in = 1'b0;
    C_out      = 1'b0;
    CON_in     = 1'b0;
    IncPC      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    ALU_select = '0;
    run        = (state != RESET) && (state != HALT);
    unique case (state)
      T0: begin
        PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1;
        Z_in = 1'b1; ALU_select = ALU_INC;
      end
      T1: begin
        ZLOW_out = 1'b1; PC_in = 1'b1; read = 1'b1;
        MDR_in = mem_ready;
      end
      T2: begin
        MDR_out = 1'b1; IR_in = 1'b1;
      end
      T3: begin
        unique case (1'b1)
          c_alu, c_imm, c_ldi, c_ld, c_st: begin
            r_out[rb] = 1'b1; Y_in = 1'b1;
          end
          c_md: begin
            r_out[ra] = 1'b1; Y_in = 1'b1;
          end
          c_neg: begin
            r_out[rb] = 1'b1; ALU_select = op; Z_in = 1'b1;
          end
          c_br: begin
            r_out[ra] = 1'b1; CON_in = 1'b1;
          end
          c_jr: begin
            r_out[ra] = 1'b1; PC_in = 1'b1;
          end
          c_jal: begin
            PC_out = 1'b1; r_in[15] = 1'b1;
          end
          c_in: begin
            inPort_out = 1'b1; r_in[ra] = 1'b1;
          end
          c_out: begin
            r_out[ra] = 1'b1; outPort_in = 1'b1;
          end
          c_mfhi: begin
            HI_out = 1'b1; r_in[ra] = 1'b1;
          end
          c_mflo: begin
            LO_out = 1'b1; r_in[ra] = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        unique case (1'b1)
          c_alu: begin
            r_out[rc] = 1'b1; ALU_select = op; Z_in = 1'b1;
          end
          c_imm: begin
            C_out = 1'b1; ALU_select = op; Z_in = 1'b1;
          end
          c_md: begin
            r_out[rb] = 1'b1; ALU_select = op; Z_in = 1'b1;
          end
          c_neg: begin
            ZLOW_out = 1'b1; r_in[ra] = 1'b1;
          end
          c_ldi, c_ld, c_st: begin
            C_out = 1'b1; ALU_select = ALU_ADD; Z_in = 1'b1;
          end
          c_br: begin
            PC_out = 1'b1; Y_in = 1'b1;
          end
          c_jal: begin
            r_out[ra] = 1'b1; PC_in = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        unique case (1'b1)
          c_alu, c_imm, c_ldi: begin
            ZLOW_out = 1'b1; r_in[ra] = 1'b1;
          end
          c_md: begin
            ZLOW_out = 1'b1; LO_in = 1'b1;
          end
          c_ld, c_st: begin
            ZLOW_out = 1'b1; MAR_in = 1'b1;
          end
          c_br: begin
            C_out = 1'b1; ALU_select = ALU_ADD; Z_in = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        unique case (1'b1)
          c_md: begin
            ZHI_out = 1'b1; HI_in = 1'b1;
          end
          c_ld: begin
            read = 1'b1; MDR_in = mem_ready;
          end
          c_st: begin
            r_out[ra] = 1'b1; MDR_in = 1'b1;
          end
          c_br: begin
            ZLOW_out = 1'b1; PC_in = CON;
          end
          default: ;
        endcase
      end
      T7: begin
        unique case (1'b1)
          c_ld: begin
            MDR_out = 1'b1; r_in[ra] = 1'b1;
          end
          c_st: write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
